axis_stream_checker: RTL

- AXI-Stream slave sink at the far end of the generator -> memory stream chain.
- Consumes the memory block's master output, checks every beat against an incrementing-counter reference and frame length, and counts frames and errors.
- Can inject periodic backpressure to exercise the upstream tready handling.
- Used as the receive-side scoreboard in hardware and simulation.

---
 rtl/axis_pkg.sv | 13 +
 rtl/axis_stream_checker_if.sv | 10 +
 rtl/axis_stall_gen.sv | 16 +
 rtl/axis_stream_checker.sv | 80 ++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared state type, default widths and saturating add for the stream checker
package axis_pkg;
  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DEF_DATA_WIDTH / 8;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/axis_stream_checker_if.sv
// axis_stream_checker_if: AXI-Stream beat bundle with master and slave views
interface axis_stream_checker_if #(parameter int DATA_WIDTH = axis_pkg::DEF_DATA_WIDTH);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master (output tdata, tstrb, tvalid, tlast, input tready);
  modport slave (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_stall_gen.sv
// axis_stall_gen: one-cycle stall pulse on every N-th accepted beat, disabled when N is 0
module axis_stall_gen #(
  parameter int N = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic beat,
  output logic stall
);
  localparam int CW = $clog2(N + 2);
  logic [CW-1:0] cnt;
  assign stall = N != 0 && beat && cnt == CW'(N - 1);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (beat) cnt <= stall ? '0 : cnt + 1'b1;
endmodule

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: AXI-Stream sink scoring incrementing-counter frames, counting frames and errors
module axis_stream_checker import axis_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_LEN = 16,
  parameter logic [DATA_WIDTH-1:0] SEED = '0,
  parameter int STALL_EVERY = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 s04_axis_aclk,
  input  logic                 s04_axis_areset,
  input  logic                 s04_axis_enable,
  axis_stream_checker_if.slave s04_axis,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic                 busy
);
  localparam int IW = $clog2(FRAME_LEN);
  state_t state;
  logic [DATA_WIDTH-1:0] expected;
  logic [IW-1:0] idx;
  logic bad;
  logic beat;
  logic stall;
  logic last_idx;
  logic beat_err;
  logic len_err;
  logic [1:0] err_inc;
  assign beat = s04_axis.tvalid && s04_axis.tready;
  assign last_idx = idx == IW'(FRAME_LEN - 1);
  assign beat_err = state == RECV && (s04_axis.tdata != expected || s04_axis.tstrb != '1);
  assign len_err = state == RECV && s04_axis.tlast != last_idx;
  assign err_inc = beat ? {1'b0, beat_err} + {1'b0, len_err} : 2'd0;
  axis_stall_gen #(.N(STALL_EVERY)) u_stall (
    .clk(s04_axis_aclk),
    .rst(s04_axis_areset),
    .beat(beat),
    .stall(stall)
  );
  always_ff @(posedge s04_axis_aclk)
    if (s04_axis_areset) begin
      state <= IDLE;
      s04_axis.tready <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
      frame_done <= 1'b0;
      frame_ok <= 1'b0;
      busy <= 1'b0;
      expected <= SEED;
      idx <= '0;
      bad <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_ok <= 1'b0;
      error_count <= CNT_WIDTH'(sat_add(32'(error_count), 32'(err_inc), CNT_WIDTH));
      if (beat) expected <= s04_axis.tdata + 1'b1;
      case (state)
        IDLE, DONE: begin
          state <= s04_axis_enable ? RECV : IDLE;
          s04_axis.tready <= s04_axis_enable;
          busy <= s04_axis_enable;
        end
        default:
          if (beat) begin
            idx <= idx + 1'b1;
            bad <= bad || err_inc != 2'd0;
            s04_axis.tready <= !(s04_axis.tlast || stall);
            if (s04_axis.tlast) begin
              state <= DONE;
              frame_done <= 1'b1;
              frame_ok <= !(bad || err_inc != 2'd0);
              frame_count <= frame_count + 1'b1;
              idx <= '0;
              bad <= 1'b0;
            end else if (state == RECV && last_idx) state <= FLUSH;
          end else s04_axis.tready <= 1'b1;
      endcase
    end
endmodule
